// File: rtl/cve2_obi_data_responder.sv
// OBI data-port responder: word-addressed RAM behind a req/gnt/rvalid handshake
// with a programmable grant wait, fixed response latency and out-of-window errors.
module cve2_obi_data_responder #(
    parameter int unsigned MemWords       = 1024,
    parameter logic [31:0] BaseAddr       = 32'h0000_0000,
    parameter int unsigned GntDelay       = 0,
    parameter int unsigned RvalidDelay    = 1,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);
    localparam int unsigned IdxW     = $clog2(MemWords);
    localparam int unsigned WaitW    = 4;
    localparam int unsigned OutW     = 4;
    localparam logic [32:0] WinBytes = 33'(MemWords) * 33'd4;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    logic [WaitW-1:0] wait_cnt;
    logic [OutW-1:0]  outstanding;
    logic [32:0]      offset;
    logic             in_range;
    logic             wait_ok;
    logic             room_ok;
    logic [IdxW-1:0]  idx;
    logic             unused_offset;
    logic [31:0]      mem [MemWords];
    resp_t            pipe [RvalidDelay];

    // 33-bit subtraction: bit 32 set means the address lies below the window
    assign offset        = {1'b0, addr_i} - {1'b0, BaseAddr};
    assign in_range      = !offset[32] && (offset < WinBytes);
    assign idx           = offset[IdxW+1:2];
    assign unused_offset = ^{offset[32:IdxW+2], offset[1:0]};

    assign wait_ok = (5'(wait_cnt) + 5'd1) > 5'(GntDelay);
    // A response leaving this cycle frees its slot for a same-cycle grant
    assign room_ok = (outstanding < OutW'(MaxOutstanding)) || rvalid_o;
    assign gnt_o   = !rst_i && req_i && wait_ok && room_ok;

    assign rvalid_o = pipe[RvalidDelay-1].valid;
    assign err_o    = pipe[RvalidDelay-1].err;
    assign rdata_o  = pipe[RvalidDelay-1].rdata;

    // Grant-wait and outstanding-transaction counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt    <= '0;
            outstanding <= '0;
        end else begin
            if (!req_i || gnt_o) begin
                wait_cnt <= '0;
            end else if (wait_cnt != {WaitW{1'b1}}) begin
                wait_cnt <= wait_cnt + WaitW'(1);
            end
            case ({gnt_o, rvalid_o})
                2'b10:   outstanding <= outstanding + OutW'(1);
                2'b01:   outstanding <= outstanding - OutW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Response shift register; idle stages carry all-zero payload
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < RvalidDelay; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0].valid <= gnt_o;
            pipe[0].err   <= gnt_o && !in_range;
            pipe[0].rdata <= (gnt_o && in_range && !we_i) ? mem[idx] : 32'h0;
            for (int unsigned i = 1; i < RvalidDelay; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // Backing RAM, byte-lane writes at the grant edge; contents survive reset
    always_ff @(posedge clk_i) begin
        if (gnt_o && in_range && we_i) begin
            for (int k = 0; k < 4; k++) begin
                if (be_i[k]) begin
                    mem[idx][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: doc/cve2_obi_data_responder.md
Name: cve2_obi_data_responder

Overview:
OBI data-port responder: the memory-side end of the core's data_req/gnt/rvalid interface. Accepts core load/store requests, backs them with an internal word-addressed RAM, and returns in-order responses after a programmable grant wait and response latency. Used in tracing/simulation tops and unit benches in place of a bus fabric. Generates bus errors for addresses outside its window.

Parameters:
MemWords, 1024, number of 32-bit words in backing RAM (power of 2, >=16)
BaseAddr, 32'h0000_0000, byte base address of window (MemWords*4 aligned)
GntDelay, 0, cycles req_i must be held before gnt_o may assert (0..15)
RvalidDelay, 1, cycles from grant edge to rvalid_o (1..8)
MaxOutstanding, 2, max granted-but-unanswered transactions (1..RvalidDelay)

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous reset, active-high
req_i  in  1  request valid from initiator
addr_i  in  32  byte address
we_i  in  1  1=store, 0=load
be_i  in  4  byte enables
wdata_i  in  32  store data
gnt_o  out  1  request accepted this cycle
rvalid_o  out  1  response valid (one cycle per transaction)
rdata_o  out  32  load data (0 for stores and errors)
err_o  out  1  bus error, qualified by rvalid_o

Behaviour:
- Reset (rst_i=1 at edge): gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0; wait counter=0; response pipeline cleared; outstanding=0. RAM contents not reset. In-flight responses dropped, never issued. gnt_o held 0 during the reset cycle.
- Wait counter: increments each cycle req_i=1 && gnt_o=0 (saturates at 15); cleared on grant or req_i=0.
- gnt_o (combinational from state and req_i): req_i && wait_cnt>=GntDelay && (outstanding<MaxOutstanding || response retiring this cycle). GntDelay=0 -> same-cycle grant.
- Initiator must hold req_i/addr_i/we_i/be_i/wdata_i stable until gnt_o; responder does not check.
- Decode at grant: in_range = addr_i>=BaseAddr && (addr_i-BaseAddr)<MemWords*4. Word index = (addr_i-BaseAddr)[log2(MemWords)+1:2]; addr_i[1:0] ignored.
- Store, in range: RAM bytes with be_i[k]=1 written with wdata_i[8k+7:8k] at grant edge; response rdata=0, err=0.
- Load, in range: full word read at grant edge (post any store at an earlier edge); response rdata=word, err=0. be_i does not mask rdata.
- Out of range: no RAM access; response rdata=0, err=1.
- Response pipeline: RvalidDelay-stage shift register {valid,rdata,err}; grant loads stage 0; rvalid_o/rdata_o/err_o driven from final stage -> rvalid_o rises exactly RvalidDelay cycles after grant edge. No backpressure on response channel. Responses strictly in grant order. Non-valid cycles: rdata_o=0, err_o=0.
- Outstanding counter: +1 on grant, -1 on rvalid_o; both same cycle -> unchanged. Never exceeds MaxOutstanding; never underflows.
- Back-to-back: with GntDelay=0 and MaxOutstanding=RvalidDelay, one grant and one response per cycle sustained.
- Store then load to same word granted on consecutive cycles: load returns merged data.
- be_i=0 store: no RAM change, normal okay response.

Test Plan:
- GntDelay=0, RvalidDelay=1: store addr 0x10 wdata 0xDEADBEEF be 4'hF, then load 0x10 -> gnt same cycle as req; rvalid one cycle after each grant; load rdata=0xDEADBEEF, err=0.
- Byte enables: preload 0x11223344 at 0x20; store be 4'b0101 wdata 0xAABBCCDD; load -> rdata=0x11BB33DD.
- Out-of-range: BaseAddr=0, MemWords=1024, load 0x1000 -> err_o=1, rdata_o=0; store 0x2000 then load 0x0 -> RAM word 0 unchanged.
- GntDelay=2, RvalidDelay=3: req asserted cycle 0 -> gnt_o in cycle 2, rvalid_o in cycle 5; wait counter clears, next held req granted 2 cycles later.
- MaxOutstanding=2, RvalidDelay=4, continuous loads of 0x0,0x4,0x8 -> two grants, gnt_o low until first rvalid, third granted in the retiring cycle; responses in order.
- Reset mid-flight: two loads granted, rst_i asserted one cycle before first response -> no rvalid_o afterwards; outstanding=0; subsequent load of previously written address returns pre-reset data.
